// File: rtl/cond_eval_unit.sv
// cond_eval_unit: ARM-style condition evaluator with a pending flag-writer
// counter. Branches stall while flag writers are still outstanding.
// Optional feature macro COND_FWD_EN: lets a branch waiting on a single
// outstanding writer resolve in the cycle that writer's flags arrive,
// evaluating on new_flags instead of flags_q.
module cond_eval_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_pend_inc,
   input  logic       flag_we,
   input  logic [3:0] new_flags,
   input  logic       br_valid,
   input  logic [3:0] br_cond,
   output logic       br_stall,
   output logic       br_done,
   output logic       br_taken,
   output logic [3:0] flags_q,
   output logic       pend_err
);

   logic [1:0] pend_cnt;
   logic       flags_ready;
   logic [3:0] eval_flags;
   logic       accept;
   logic       cond_pass;

   // ARM condition table on {N,Z,C,V}
   function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      logic res;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cc)
         4'b0000: res = z;
         4'b0001: res = !z;
         4'b0010: res = c;
         4'b0011: res = !c;
         4'b0100: res = n;
         4'b0101: res = !n;
         4'b0110: res = v;
         4'b0111: res = !v;
         4'b1000: res = c & !z;
         4'b1001: res = !(c & !z);
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = !z & (n == v);
         4'b1101: res = !(!z & (n == v));
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   // Readiness and the flag source used for evaluation
   always_comb begin
      flags_ready = (pend_cnt == 2'd0);
      eval_flags  = flags_q;
`ifdef COND_FWD_EN
      if (pend_cnt == 2'd1 && flag_we) begin
         flags_ready = 1'b1;
         eval_flags  = new_flags;
      end
`endif
      br_stall  = br_valid & !flags_ready;
      accept    = br_valid & !br_stall;
      cond_pass = cond_true(br_cond, eval_flags);
   end

   // Architectural flag register
   always_ff @(posedge clk) begin
      if (reset)
         flags_q <= '0;
      else if (flag_we)
         flags_q <= new_flags;
   end

   // Pending writer counter with sticky saturation error
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_cnt <= '0;
         pend_err <= 1'b0;
      end else begin
         case ({flag_pend_inc, flag_we})
            2'b10: begin
               if (pend_cnt == 2'd3)
                  pend_err <= 1'b1;
               else
                  pend_cnt <= pend_cnt + 2'd1;
            end
            2'b01: begin
               if (pend_cnt != 2'd0)
                  pend_cnt <= pend_cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Branch resolution pulse and result
   always_ff @(posedge clk) begin
      if (reset) begin
         br_done  <= 1'b0;
         br_taken <= 1'b0;
      end else begin
         br_done <= accept;
         if (accept)
            br_taken <= cond_pass;
      end
   end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: directed scenarios plus random
// traffic, all compared against a behavioural model held in this module.
module tb_cond_eval_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       flag_pend_inc;
   logic       flag_we;
   logic [3:0] new_flags;
   logic       br_valid;
   logic [3:0] br_cond;
   logic       br_stall;
   logic       br_done;
   logic       br_taken;
   logic [3:0] flags_q;
   logic       pend_err;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic [3:0] m_flags = '0;
   int         m_pend  = 0;
   logic       m_err   = 1'b0;
   logic       m_done  = 1'b0;
   logic       m_taken = 1'b0;
   logic       m_rst_seen = 1'b0;

   cond_eval_unit dut (
      .clk           (clk),
      .reset         (reset),
      .flag_pend_inc (flag_pend_inc),
      .flag_we       (flag_we),
      .new_flags     (new_flags),
      .br_valid      (br_valid),
      .br_cond       (br_cond),
      .br_stall      (br_stall),
      .br_done       (br_done),
      .br_taken      (br_taken),
      .flags_q       (flags_q),
      .pend_err      (pend_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Condition codes come in pairs: odd code is the inverse of the even one,
   // except the always-taken pair at the top.
   function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
      bit n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cc[3:1] != 3'd7 && cc[0])
         base = !base;
      return base;
   endfunction

   function automatic bit fwd_now(input logic we);
`ifdef COND_FWD_EN
      return (m_pend == 1) && we;
`else
      return 1'b0 & we;
`endif
   endfunction

   // One clock cycle: drive, check the combinational stall, then check
   // registered outputs against the model after the edge.
   task automatic step(input logic rst, input logic inc, input logic we,
                       input logic [3:0] nf, input logic bv, input logic [3:0] cc,
                       output logic st);
      bit ready, exp_stall, acc;
      logic [3:0] src;
      @(negedge clk);
      reset = rst; flag_pend_inc = inc; flag_we = we;
      new_flags = nf; br_valid = bv; br_cond = cc;
      #1;
      ready     = (m_pend == 0) || fwd_now(we);
      exp_stall = bv && !ready;
      check("br_stall", 4'(br_stall), 4'(exp_stall));
      st = br_stall;
      @(posedge clk);
      if (rst) begin
         m_flags = '0; m_pend = 0; m_err = 1'b0; m_done = 1'b0; m_taken = 1'b0;
         m_rst_seen = 1'b1;
      end else begin
         acc = bv && !exp_stall;
         src = fwd_now(we) ? nf : m_flags;
         m_done = acc;
         if (acc) m_taken = ref_cond(cc, src);
         if (we) m_flags = nf;
         if (inc && !we) begin
            if (m_pend == 3) m_err = 1'b1;
            else m_pend++;
         end else if (we && !inc && m_pend > 0) begin
            m_pend--;
         end
      end
      #1;
      if (m_rst_seen) begin
         check("br_done", 4'(br_done), 4'(m_done));
         check("flags_q", flags_q, m_flags);
         check("pend_err", 4'(pend_err), 4'(m_err));
         if (m_done || rst)
            check("br_taken", 4'(br_taken), 4'(m_taken));
      end
   endtask

   initial begin
      logic st;
      int   stalls;
      bit   got_done;

      // reset, then an always-taken branch
      step(1, 0, 0, 4'h0, 0, 4'h0, st);
      step(1, 1, 1, 4'hF, 1, 4'hE, st);
      step(0, 0, 0, 4'h0, 1, 4'hE, st);
      check("al_stall", 4'(st), 4'h0);
      check("al_done", 4'(br_done), 4'h1);
      check("al_taken", 4'(br_taken), 4'h1);
      check("al_flags", flags_q, 4'h0);

      // Z set: BEQ taken, BNE not
      step(0, 0, 1, 4'h4, 0, 4'h0, st);
      step(0, 0, 0, 4'h0, 1, 4'h0, st);
      check("beq_taken", 4'(br_taken), 4'h1);
      step(0, 0, 0, 4'h0, 1, 4'h1, st);
      check("bne_taken", 4'(br_taken), 4'h0);

      // one outstanding writer, branch LT waiting on it
      step(1, 0, 0, 4'h0, 0, 4'h0, st);
      step(0, 1, 0, 4'h0, 0, 4'h0, st);
      step(0, 0, 0, 4'h0, 0, 4'h0, st);
      stalls = 0; got_done = 1'b0;
      for (int i = 0; i < 5 && !got_done; i++) begin
         step(0, 0, (i == 1), 4'h8, 1, 4'hB, st);
         if (st) stalls++;
         else got_done = 1'b1;
      end
      check("fwd_accept", 4'(got_done), 4'h1);
`ifdef COND_FWD_EN
      check("fwd_stalls", 4'(stalls), 4'd1);
`else
      check("fwd_stalls", 4'(stalls), 4'd2);
`endif
      step(0, 0, 0, 4'h0, 0, 4'h0, st);
      check("fwd_taken", 4'(br_taken), 4'h1);

      // counter saturation and sticky error
      step(1, 0, 0, 4'h0, 0, 4'h0, st);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 4'h0, 0, 4'h0, st);
      check("sat_err", 4'(pend_err), 4'h1);
      step(0, 1, 1, 4'h3, 1, 4'hE, st);
      check("sat_stall", 4'(st), 4'h1);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 4'h3, 0, 4'h0, st);
      step(0, 0, 0, 4'h0, 1, 4'hE, st);
      check("sat_hold", 4'(st), 4'h1);
      step(0, 0, 1, 4'h3, 0, 4'h0, st);
      step(0, 0, 0, 4'h0, 1, 4'hE, st);
      check("sat_drain", 4'(st), 4'h0);
      check("err_sticky", 4'(pend_err), 4'h1);

      // reset while stalled with two pending
      step(1, 0, 0, 4'h0, 0, 4'h0, st);
      step(0, 1, 0, 4'h0, 0, 4'h0, st);
      step(0, 1, 0, 4'h0, 1, 4'h0, st);
      step(1, 0, 0, 4'h0, 1, 4'h0, st);
      check("rst_done", 4'(br_done), 4'h0);
      step(0, 0, 0, 4'h0, 1, 4'h0, st);
      check("rst_stall", 4'(st), 4'h0);

      // full condition sweep
      for (int f = 0; f < 16; f++) begin
         step(0, 0, 1, 4'(f), 0, 4'h0, st);
         for (int c = 0; c < 16; c++)
            step(0, 0, 0, 4'h0, 1, 4'(c), st);
      end

      // random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 1) == 1),
              4'($urandom), st);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
